// File: rtl/disp_src_sched.sv
// disp_src_sched: time-shares the 7-segment display between two periodic
// sources and a preemptive alarm source. Picks a source on a dwell schedule,
// converts its 11-bit value field data[15:5] to 3-digit BCD with a serial
// double-dabble engine, and presents a stable BCD word plus source tag.
// Optional build macro DISP_SIGN_EN: treat bit 15 as a two's-complement sign,
// display the magnitude, and add the disp_neg output.
module disp_src_sched #(
  parameter int DWELL_CYC = 100000000,
  parameter int CLAMP_MAX = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] src0_data,
  input  logic        src0_vld,
  input  logic [15:0] src1_data,
  input  logic        src1_vld,
  input  logic        alarm_req,
  input  logic [15:0] alarm_data,
  output logic [11:0] disp_bcd,
  output logic [1:0]  disp_src,
  output logic        disp_upd,
`ifdef DISP_SIGN_EN
  output logic        disp_neg,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

  localparam int             CW         = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [10:0]    CLAMP      = 11'(CLAMP_MAX);
  localparam logic [1:0]     TAG_SRC0   = 2'd0;
  localparam logic [1:0]     TAG_SRC1   = 2'd1;
  localparam logic [1:0]     TAG_ALARM  = 2'd2;
  localparam logic [1:0]     TAG_NONE   = 2'd3;

  state_t        r_state, w_next;
  logic [CW-1:0] r_dwell;
  logic          r_init;      // high only in the first cycle after reset release
  logic          r_alarm_d;   // alarm_req delayed one cycle, for edge detection
  logic          r_pend;      // one-deep pending start while a conversion runs
  logic          r_rr;        // round-robin pointer: 0 = src0 first, 1 = src1 first
  logic [10:0]   r_bin;
  logic [11:0]   r_bcd;
  logic [3:0]    r_cnt;
  logic [1:0]    r_tag;
  logic [11:0]   r_disp_bcd;
  logic [1:0]    r_disp_src;
  logic          r_disp_upd;
`ifdef DISP_SIGN_EN
  logic          r_neg;
  logic          r_disp_neg;
`endif

  logic          w_start;
  logic          w_busy;
  logic [1:0]    w_sel_tag;
  logic [10:0]   w_sel_field;
  logic          w_sel_sign;
  logic [10:0]   w_mag;
  logic [10:0]   w_clamped;
  logic [11:0]   w_adj;
  logic [11:0]   w_bcd_step;
  logic [10:0]   w_bin_step;
  logic          w_last;
  // Low bits of the source words carry no displayed value.
  logic          w_unused;

  assign w_unused = ^{src0_data[4:0], src1_data[4:0], alarm_data[4:0]};

  // Start event: dwell expiry, either alarm edge, or first cycle out of reset.
  assign w_start = (r_dwell == DWELL_LAST) || (alarm_req != r_alarm_d) || r_init;

  // Source selection: alarm preempts, then RR pointer source, then the other.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_tag = TAG_NONE;
    if (alarm_req)                w_sel_tag = TAG_ALARM;
    else if (!r_rr && src0_vld)   w_sel_tag = TAG_SRC0;
    else if (src1_vld)            w_sel_tag = TAG_SRC1;
    else if (src0_vld)            w_sel_tag = TAG_SRC0;
  end

  // Value field mux and magnitude/clamp of the selected word.
  always_comb begin
    w_sel_field = '0;
    w_sel_sign  = 1'b0;
    case (w_sel_tag)
      TAG_SRC0:  begin w_sel_field = src0_data[15:5];  w_sel_sign = src0_data[15];  end
      TAG_SRC1:  begin w_sel_field = src1_data[15:5];  w_sel_sign = src1_data[15];  end
      TAG_ALARM: begin w_sel_field = alarm_data[15:5]; w_sel_sign = alarm_data[15]; end
      default:   begin w_sel_field = '0;               w_sel_sign = 1'b0;           end
    endcase
`ifdef DISP_SIGN_EN
    w_mag = w_sel_sign ? (~w_sel_field + 11'd1) : w_sel_field;
`else
    w_mag = w_sel_field;
`endif
    w_clamped = (w_mag > CLAMP) ? CLAMP : w_mag;
  end

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the binary MSB.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_step = {w_adj[10:0], r_bin[10]};
    w_bin_step = {r_bin[9:0], 1'b0};
    w_last     = (r_cnt == 4'd10);
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic; a pending or coincident start is taken straight from DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = LOAD;
      LOAD:    w_next = (w_sel_tag == TAG_NONE) ? DONE : CONV;
      CONV:    if (w_last) w_next = DONE;
      DONE:    w_next = (r_pend || w_start) ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers the load and the conversion.
  always_comb begin
    w_busy = (r_state == LOAD) || (r_state == CONV);
  end

  // Datapath: dwell counter, edge/pending tracking, conversion engine, output regs.
  // NOTE: every register here is a plain flop, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell    <= '0;
      r_init     <= 1'b1;
      r_alarm_d  <= 1'b0;
      r_pend     <= 1'b0;
      r_rr       <= 1'b0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_tag      <= TAG_NONE;
      r_disp_bcd <= 12'h000;
      r_disp_src <= TAG_NONE;
      r_disp_upd <= 1'b0;
`ifdef DISP_SIGN_EN
      r_neg      <= 1'b0;
      r_disp_neg <= 1'b0;
`endif
    end else begin
      r_dwell    <= (r_dwell == DWELL_LAST) ? '0 : r_dwell + 1'b1;
      r_init     <= 1'b0;
      r_alarm_d  <= alarm_req;
      r_disp_upd <= 1'b0;

      if (w_start && w_busy)  r_pend <= 1'b1;
      else if (w_next == LOAD) r_pend <= 1'b0;

      case (r_state)
        LOAD: begin
          r_bin <= w_clamped;
          r_bcd <= '0;
          r_cnt <= '0;
          r_tag <= w_sel_tag;
`ifdef DISP_SIGN_EN
          r_neg <= w_sel_sign;
`endif
          if (w_sel_tag == TAG_SRC0 || w_sel_tag == TAG_SRC1) r_rr <= ~r_rr;
          if (w_sel_tag == TAG_NONE) begin
            r_disp_bcd <= 12'h000;
            r_disp_src <= TAG_NONE;
            r_disp_upd <= 1'b1;
`ifdef DISP_SIGN_EN
            r_disp_neg <= 1'b0;
`endif
          end
        end
        CONV: begin
          r_bcd <= w_bcd_step;
          r_bin <= w_bin_step;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_disp_bcd <= w_bcd_step;
            r_disp_src <= r_tag;
            r_disp_upd <= 1'b1;
`ifdef DISP_SIGN_EN
            r_disp_neg <= r_neg;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_bcd = r_disp_bcd;
  assign disp_src = r_disp_src;
  assign disp_upd = r_disp_upd;
  assign busy     = w_busy;
`ifdef DISP_SIGN_EN
  assign disp_neg = r_disp_neg;
`endif

endmodule

// File: tb/tb_disp_src_sched.sv
// Testbench for disp_src_sched with a short dwell period. Stimulus pushes the
// expected display word into a queue; a monitor pops and compares on every
// disp_upd pulse. Latency and reset behaviour are checked directly.
module tb_disp_src_sched;

  typedef struct {
    logic [11:0] bcd;
    logic [1:0]  src;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] src0_data, src1_data, alarm_data;
  logic        src0_vld, src1_vld, alarm_req;
  logic [11:0] disp_bcd;
  logic [1:0]  disp_src;
  logic        disp_upd, busy;
`ifdef DISP_SIGN_EN
  logic        disp_neg;
`endif

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n;

  disp_src_sched #(.DWELL_CYC(32), .CLAMP_MAX(999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_data  (src0_data),
    .src0_vld   (src0_vld),
    .src1_data  (src1_data),
    .src1_vld   (src1_vld),
    .alarm_req  (alarm_req),
    .alarm_data (alarm_data),
    .disp_bcd   (disp_bcd),
    .disp_src   (disp_src),
    .disp_upd   (disp_upd),
`ifdef DISP_SIGN_EN
    .disp_neg   (disp_neg),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [11:0] bcd, input logic [1:0] src, input logic neg);
    exp_t e;
    e.bcd = bcd; e.src = src; e.neg = neg;
    q.push_back(e);
  endtask

  // Count negedges until disp_upd is seen; a missed pulse is a failed check.
  task automatic wait_upd(input string name, output int cyc);
    logic found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (disp_upd === 1'b1) begin found = 1'b1; break; end
    end
    check({name, "_upd_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_busy(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin found = 1'b1; break; end
    end
    check({name, "_busy_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_bcd"},  {20'd0, disp_bcd}, 32'h000);
    check({name, "_src"},  {30'd0, disp_src}, 32'd3);
    check({name, "_upd"},  {31'd0, disp_upd}, 32'd0);
    check({name, "_busy"}, {31'd0, busy},     32'd0);
`ifdef DISP_SIGN_EN
    check({name, "_neg"},  {31'd0, disp_neg}, 32'd0);
`endif
  endtask

  // Scoreboard monitor: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && disp_upd === 1'b1) begin
      check("upd_expected", {31'd0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("disp_bcd", {20'd0, disp_bcd}, {20'd0, e.bcd});
        check("disp_src", {30'd0, disp_src}, {30'd0, e.src});
        check("busy_at_upd", {31'd0, busy}, 32'd0);
`ifdef DISP_SIGN_EN
        check("disp_neg", {31'd0, disp_neg}, {31'd0, e.neg});
`endif
      end
    end
  end

  // 0x7FF field: clamped unsigned, or -1 when bit 15 is a sign.
`ifdef DISP_SIGN_EN
  localparam logic [11:0] BCD_7FF = 12'h001;
  localparam logic        NEG_7FF = 1'b1;
`else
  localparam logic [11:0] BCD_7FF = 12'h999;
  localparam logic        NEG_7FF = 1'b0;
`endif

  initial begin
    rst_n      = 1'b0;
    src0_data  = 16'h0C80;   // field 100
    src0_vld   = 1'b1;
    src1_data  = 16'h0000;
    src1_vld   = 1'b0;
    alarm_req  = 1'b0;
    alarm_data = 16'h0000;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    // First start right after reset release: src0 field 100.
    push(12'h100, 2'd0, 1'b0);
    rst_n = 1'b1;
    wait_upd("init", n);
    check("lat_init", n, 13);

    // Both valid: RR pointer now at src1, then back to src0.
    src0_data = 16'h0320;    // field 25
    src1_data = 16'h04A0;    // field 37
    src1_vld  = 1'b1;
    push(12'h037, 2'd1, 1'b0);
    push(12'h025, 2'd0, 1'b0);
    wait_upd("rr_a", n);
    wait_upd("rr_b", n);

    // src1 invalid: src0 shown every period.
    src1_vld = 1'b0;
    push(12'h025, 2'd0, 1'b0);
    push(12'h025, 2'd0, 1'b0);
    wait_upd("skip_a", n);
    wait_upd("skip_b", n);

    // Nothing valid: "none" word, RR pointer (now src1) unchanged.
    src0_vld = 1'b0;
    push(12'h000, 2'd3, 1'b0);
    wait_upd("none", n);

    // Alarm rises mid-dwell with field 512.
    src0_vld   = 1'b1;
    src1_vld   = 1'b1;
    alarm_data = 16'h4000;
    repeat (5) @(negedge clk);
    push(12'h512, 2'd2, 1'b0);
    alarm_req = 1'b1;
    wait_upd("alarm_rise", n);
    check("lat_alarm_rise", n, 13);

    // Alarm held: periodic event refreshes the alarm.
    push(12'h512, 2'd2, 1'b0);
    wait_upd("alarm_refresh", n);

    // Alarm falls: rotation resumes at src1, then src0.
    repeat (2) @(negedge clk);
    push(12'h037, 2'd1, 1'b0);
    push(12'h025, 2'd0, 1'b0);
    alarm_req = 1'b0;
    wait_upd("alarm_fall", n);
    check("lat_alarm_fall", n, 13);
    wait_upd("resume", n);

    // Field 0x7FF on src0; an alarm rise during its conversion is held pending.
    src0_data  = 16'hFFE0;
    src1_vld   = 1'b0;
    alarm_data = 16'h2580;   // field 300
    push(BCD_7FF, 2'd0, NEG_7FF);
    wait_busy("clamp");
    repeat (3) @(negedge clk);
    push(12'h300, 2'd2, 1'b0);
    alarm_req = 1'b1;
    wait_upd("clamp", n);
    wait_upd("pending", n);
    check("pending_gap", n, 13);
    push(12'h300, 2'd2, 1'b0);
    wait_upd("pending_refresh", n);
    repeat (2) @(negedge clk);
    push(BCD_7FF, 2'd0, NEG_7FF);
    alarm_req = 1'b0;
    wait_upd("clamp_fall", n);

    // Reset in the middle of a conversion; the in-flight result never appears.
    src0_data = 16'h0320;
    src1_vld  = 1'b1;
    wait_busy("midconv");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midconv_reset");
    repeat (2) @(negedge clk);
    push(12'h025, 2'd0, 1'b0);
    rst_n = 1'b1;
    wait_upd("post_reset", n);
    check("lat_post_reset", n, 13);
    push(12'h037, 2'd1, 1'b0);
    wait_upd("post_reset_rr", n);

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
